// File: rtl/vga_capture.sv
// VGA stream receiver: recovers frame/line/pixel position from an oversampled
// VGA-style stream, writes active pixels to a frame memory port and checks geometry.
module vga_capture #(
  parameter int   H_ACTIVE = 640,
  parameter int   V_ACTIVE = 480,
  parameter int   ADDR_W   = 19,
  parameter logic SYNC_ACT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              one_shot,
  input  logic              err_clr,
  input  logic              pixlclk,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank_b,
  input  logic [7:0]        R,
  input  logic [7:0]        G,
  input  logic [7:0]        B,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic              line_err,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam int X_W = $clog2(H_ACTIVE + 1);
  localparam int Y_W = $clog2(V_ACTIVE + 2);
  localparam logic [X_W-1:0]    X_END = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]    Y_END = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]    Y_SAT = Y_W'(V_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] A_END = ADDR_W'(H_ACTIVE * V_ACTIVE);

  typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_END, ACTIVE} state_t;

  typedef struct packed {
    logic        pixlclk;
    logic        hsync;
    logic        vsync;
    logic        blank_b;
    logic [23:0] rgb;
  } sample_t;

  state_t            state, state_nxt;
  sample_t           s1, s2;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr;
  logic              prev_active;

  logic pix_stb, vs_act;
  logic do_start, do_write, do_eol, do_eof, act_stb;
  logic line_set, frame_set;

  assign pix_stb = s1.pixlclk & ~s2.pixlclk;
  assign vs_act  = (s1.vsync == SYNC_ACT);

  // Both stages carry the whole stream so s2 is a true delayed copy; only
  // pixlclk is consumed from s2 and hsync is carried but never decoded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      s1 <= '{pixlclk: pixlclk, hsync: hsync, vsync: vsync, blank_b: blank_b, rgb: {R, G, B}};
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_nxt = state;
    do_start  = 1'b0;
    do_write  = 1'b0;
    do_eol    = 1'b0;
    do_eof    = 1'b0;
    act_stb   = 1'b0;
    unique case (state)
      IDLE:     if (capture_en) state_nxt = WAIT_VS;
      WAIT_VS: begin
        if (!capture_en)           state_nxt = IDLE;
        else if (pix_stb && vs_act) state_nxt = WAIT_END;
      end
      WAIT_END: begin
        if (!capture_en) state_nxt = IDLE;
        else if (pix_stb && !vs_act) begin
          do_start  = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: if (pix_stb) begin
        if (vs_act) begin
          do_eof    = 1'b1;
          state_nxt = (one_shot || !capture_en) ? IDLE : WAIT_END;
        end else if (s1.blank_b) begin
          act_stb  = 1'b1;
          do_write = (x < X_END) && (y < Y_END);
        end else if (prev_active) begin
          do_eol = 1'b1;
        end
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // A short line leaves the write count below H_ACTIVE*V_ACTIVE even when the
  // line count is right, so the frame check also compares the final address.
  always_comb begin
    line_set  = (act_stb && x >= X_END) || (do_eol && x != X_END);
    frame_set = (act_stb && y >= Y_END) || (do_eof && (y != Y_END || addr != A_END));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      prev_active <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      wr_en      <= do_write;
      frame_done <= do_eof;

      if (do_start) begin
        x           <= '0;
        y           <= '0;
        addr        <= '0;
        prev_active <= 1'b0;
        busy        <= 1'b1;
      end

      if (state == ACTIVE && pix_stb && !vs_act) prev_active <= s1.blank_b;

      if (do_write) begin
        wr_addr <= addr;
        wr_data <= s1.rgb;
        addr    <= addr + 1'b1;
        x       <= x + 1'b1;
      end

      if (do_eol) begin
        x <= '0;
        if (y != Y_SAT) y <= y + 1'b1;
      end

      if (do_eof) begin
        frame_count <= frame_count + 1'b1;
        busy        <= 1'b0;
      end

      if (line_set)     line_err <= 1'b1;
      else if (err_clr) line_err <= 1'b0;

      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the VGA timing and pixel generator.
- Samples a VGA-style stream (pixlclk, hsync, vsync, blank_b, R/G/B) in the system clock domain and recovers frame, line and pixel position.
- Writes each active pixel into a frame memory through a simple write port, and checks line and frame geometry.
- Used for loopback self-test of the display path and as a bench monitor.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- ADDR_W, 19, frame memory address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- SYNC_ACT, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock; must be at least 2x the pixlclk frequency
- reset  in  1  asynchronous reset, active-high
- capture_en  in  1  arm capture; sampled at frame start
- one_shot  in  1  1 = stop after one frame; 0 = continuous
- err_clr  in  1  one-cycle pulse that clears sticky error flags
- pixlclk  in  1  pixel clock from the generator, treated as data
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- blank_b  in  1  1 = active video
- R, G, B  in  8 each  pixel colour
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_W  linear address, y*H_ACTIVE + x
- wr_data  out  24  {R,G,B}
- frame_done  out  1  one-cycle pulse at end of a captured frame
- busy  out  1  a frame is being captured
- line_err  out  1  sticky: active line length != H_ACTIVE
- frame_err  out  1  sticky: active line count != V_ACTIVE, or pixel outside geometry
- frame_count  out  16  completed captured frames; wraps at 0xFFFF

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters and sample registers cleared. Reset is asynchronous and may occur mid-frame: capture aborts and no further wr_en is issued.
- Input sampling: two register stages, s1 then s2, sample all stream inputs on every clk edge.
  - pix_stb = s1.pixlclk & ~s2.pixlclk.
  - Stream values are taken from s1 in the strobe cycle.
- vs_act = (s1.vsync == SYNC_ACT). hsync is sampled and ignored; line boundaries come from blank_b.
- FSM:
  - IDLE: busy=0. When capture_en=1, go to WAIT_VS.
  - WAIT_VS: wait for a strobe with vs_act=1, then go to WAIT_END.
  - WAIT_END: on the first strobe with vs_act=0:
    - clear x, y and addr;
    - busy=1;
    - go to ACTIVE.
  - ACTIVE, on each strobe:
    - blank_b=1 and x<H_ACTIVE and y<V_ACTIVE: write pixel; x++, addr++.
    - blank_b=1 and (x>=H_ACTIVE or y>=V_ACTIVE): no write. x>=H_ACTIVE sets line_err; y>=V_ACTIVE sets frame_err.
    - blank_b 1->0 transition (previous strobe active): end of line. If x != H_ACTIVE, set line_err. x<=0; y++ saturating at V_ACTIVE+1. addr is not adjusted, so short lines shift later addresses. line_err records this.
    - vs_act=1: end of frame. If y != V_ACTIVE, set frame_err. Pulse frame_done; frame_count++; busy=0. Then:
      - if one_shot=1 or capture_en=0, go to IDLE;
      - otherwise go to WAIT_END, so the next frame starts after this vsync.
  - capture_en falling mid-frame: the current frame completes normally.
- Write timing: a strobe detected in cycle n gives wr_en=1 in cycle n+1, registered, exactly one cycle. wr_addr and wr_data are valid in the same cycle; wr_data = s1 {R,G,B} from cycle n.
- Latency: pixlclk first sampled high at clk edge k gives wr_en high after edge k+1.
- frame_done is asserted in the cycle after the terminating strobe and never coincides with wr_en.
- err_clr clears line_err and frame_err. If err_clr and a new error set occur in the same cycle, set wins.
- frame_count is not cleared by err_clr.

Test Plan:
- Reset values: assert reset for 2 cycles with stimulus toggling -> all outputs 0; no wr_en during or after reset while capture_en=0.
- Nominal frame, H_ACTIVE=4, V_ACTIVE=3, pixlclk=clk/2, pixel value = address, one_shot=1 -> 12 writes:
  - wr_addr 0..11, wr_data 0x000000..0x00000B;
  - one frame_done pulse; frame_count=1; no errors; back to IDLE.
- Short line (line 1 has 3 pixels) -> line_err=1; 11 writes; frame_err=1, since y still reaches 3 but 11 writes leave addresses shifted, and frame_done still pulses. Then err_clr -> both flags 0.
- Extra line (4 active lines) -> frame_err=1; line 3 pixels produce no wr_en; wr_addr never exceeds 11.
- Continuous mode, one_shot=0, 3 frames -> 3 frame_done pulses; frame_count=3; addresses restart at 0 each frame. Deassert capture_en mid frame 3 -> frame 3 completes, then IDLE.
- Reset asserted during line 1 of a frame -> wr_en drops immediately; busy=0. After release, capture restarts only after the next complete vsync.
